mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 43 ++++
 rtl/mem_access_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Bundle of the EX-to-MEM handshake, the data-memory bus and the write-back slot.
// The slave modport is the memory-access stage; the master modport is its
// environment (EX stage, data memory and write-back consumer together).
interface mem_access_stage_if;
    logic        ex_valid;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic        flag;
    logic        BranchD;
    logic        flush;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        branch_taken;
    logic        misaligned_exc;
    logic        bus_err;

    modport slave (
        input  ex_valid, alu_out, write_data, mem_read, mem_write, reg_write,
               rd, flag, BranchD, flush, dmem_rdata, dmem_ack,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid,
               wb_data, wb_rd, wb_reg_write, branch_taken, misaligned_exc, bus_err
    );

    modport master (
        output ex_valid, alu_out, write_data, mem_read, mem_write, reg_write,
               rd, flag, BranchD, flush, dmem_rdata, dmem_ack,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid,
               wb_data, wb_rd, wb_reg_write, branch_taken, misaligned_exc, bus_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage. Non-memory instructions pass straight to the
// write-back slot; aligned loads/stores hold the pipeline (stall) in WAIT until
// the memory acknowledges or the wait budget runs out. Misaligned accesses are
// refused without touching the bus. All outputs except stall are registered.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_stage_if.slave     bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic          r_req, r_we, r_load, r_regw;
    logic [31:0]   r_addr, r_wdata;
    logic [4:0]    r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_wb_valid, r_wb_regw, r_branch, r_mis, r_berr;
    logic [31:0]   r_wb_data;
    logic [4:0]    r_wb_rd;

    logic          w_req, w_we, w_load, w_regw;
    logic [31:0]   w_addr, w_wdata;
    logic [4:0]    w_rd;
    logic [CW-1:0] w_cnt;
    logic          w_wb_valid, w_wb_regw, w_branch, w_mis, w_berr;
    logic [31:0]   w_wb_data;
    logic [4:0]    w_wb_rd;

    logic w_accept, w_is_mem, w_misaligned, w_ack, w_timeout;

    // An ack only counts while a request is actually on the bus.
    assign w_accept     = (r_state == ST_IDLE) && bus.ex_valid && !bus.flush;
    assign w_is_mem     = bus.mem_read || bus.mem_write;
    assign w_misaligned = (bus.alu_out[1:0] != 2'b00);
    assign w_ack        = bus.dmem_ack && r_req;
    assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter WAIT only for an accepted aligned memory op.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mem && !w_misaligned) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values: latched bus fields hold, pulses default low.
    always_comb begin
        w_req      = r_req;
        w_we       = r_we;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_rd       = r_rd;
        w_load     = r_load;
        w_regw     = r_regw;
        w_cnt      = r_cnt;
        w_wb_valid = 1'b0;
        w_wb_data  = 32'h0000_0000;
        w_wb_rd    = 5'd0;
        w_wb_regw  = 1'b0;
        w_branch   = 1'b0;
        w_mis      = 1'b0;
        w_berr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_branch = bus.flag && bus.BranchD;
                    if (w_is_mem && w_misaligned) begin
                        w_wb_valid = 1'b1;
                        w_wb_data  = bus.alu_out;
                        w_wb_rd    = bus.rd;
                        w_mis      = 1'b1;
                    end else if (w_is_mem) begin
                        // A store wins when both read and write are flagged.
                        w_req   = 1'b1;
                        w_we    = bus.mem_write;
                        w_addr  = bus.alu_out;
                        w_wdata = bus.write_data;
                        w_rd    = bus.rd;
                        w_load  = bus.mem_read && !bus.mem_write;
                        w_regw  = bus.reg_write;
                        w_cnt   = '0;
                    end else begin
                        w_wb_valid = 1'b1;
                        w_wb_data  = bus.alu_out;
                        w_wb_rd    = bus.rd;
                        w_wb_regw  = bus.reg_write && (bus.rd != 5'd0);
                    end
                end else begin
                    w_cnt = '0;
                end
            end
            ST_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_req      = 1'b0;
                    w_we       = 1'b0;
                    w_addr     = 32'h0000_0000;
                    w_wdata    = 32'h0000_0000;
                    w_cnt      = '0;
                    w_wb_valid = 1'b1;
                    w_wb_rd    = r_rd;
                    if (w_ack) begin
                        w_wb_data = r_load ? bus.dmem_rdata : r_addr;
                        w_wb_regw = r_load && r_regw && (r_rd != 5'd0);
                    end else begin
                        w_wb_data = r_addr;
                        w_berr    = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_req = 1'b0;
                w_cnt = '0;
            end
        endcase
    end

    // Datapath and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_rd       <= 5'd0;
            r_load     <= 1'b0;
            r_regw     <= 1'b0;
            r_cnt      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'h0000_0000;
            r_wb_rd    <= 5'd0;
            r_wb_regw  <= 1'b0;
            r_branch   <= 1'b0;
            r_mis      <= 1'b0;
            r_berr     <= 1'b0;
        end else begin
            r_req      <= w_req;
            r_we       <= w_we;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_rd       <= w_rd;
            r_load     <= w_load;
            r_regw     <= w_regw;
            r_cnt      <= w_cnt;
            r_wb_valid <= w_wb_valid;
            r_wb_data  <= w_wb_data;
            r_wb_rd    <= w_wb_rd;
            r_wb_regw  <= w_wb_regw;
            r_branch   <= w_branch;
            r_mis      <= w_mis;
            r_berr     <= w_berr;
        end
    end

    assign bus.stall          = (r_state == ST_WAIT);
    assign bus.dmem_req       = r_req;
    assign bus.dmem_we        = r_we;
    assign bus.dmem_addr      = r_addr;
    assign bus.dmem_wdata     = r_wdata;
    assign bus.wb_valid       = r_wb_valid;
    assign bus.wb_data        = r_wb_data;
    assign bus.wb_rd          = r_wb_rd;
    assign bus.wb_reg_write   = r_wb_regw;
    assign bus.branch_taken   = r_branch;
    assign bus.misaligned_exc = r_mis;
    assign bus.bus_err        = r_berr;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expected write-back
// records into a queue; a negedge monitor pops and compares each wb_valid pulse.
module tb_mem_access_stage;
    logic clk;
    logic rst_n;
    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        regw;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic chk_data, input logic [4:0] rd,
                        input logic regw, input logic mis, input logic berr);
        exp_t e;
        e.data = data; e.chk_data = chk_data; e.rd = rd;
        e.regw = regw; e.mis = mis; e.berr = berr;
        sb_q.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.ex_valid = 1'b0; bus.alu_out = 32'h0; bus.write_data = 32'h0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.reg_write = 1'b0;
        bus.rd = 5'd0; bus.flag = 1'b0; bus.BranchD = 1'b0; bus.flush = 1'b0;
        bus.dmem_rdata = 32'h0; bus.dmem_ack = 1'b0;
    endtask

    // Present one instruction for a single edge, then withdraw it.
    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic rw,
                         input logic fl, input logic br, input logic fls);
        bus.ex_valid = 1'b1; bus.alu_out = alu; bus.write_data = wd; bus.rd = rd;
        bus.mem_read = mr; bus.mem_write = mw; bus.reg_write = rw;
        bus.flag = fl; bus.BranchD = br; bus.flush = fls;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // Count request cycles, acking on cycle ack_at (0 = never); bounded at 40.
    task automatic run_wait(input int ack_at, input logic [31:0] rdata,
                            input logic [31:0] addr, output int n);
        logic stable;
        n = 0;
        stable = 1'b1;
        while (bus.dmem_req === 1'b1 && n < 40) begin
            n++;
            if (bus.dmem_addr !== addr || bus.stall !== 1'b1) stable = 1'b0;
            if (n == ack_at) begin
                bus.dmem_ack = 1'b1;
                bus.dmem_rdata = rdata;
            end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            bus.dmem_rdata = 32'h0;
        end
        chk("wait_addr_stall_stable", {31'd0, stable}, 32'd1);
    endtask

    // Scoreboard monitor: every write-back pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk_data) chk("wb_data", bus.wb_data, e.data);
                chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
                chk("wb_reg_write", {31'd0, bus.wb_reg_write}, {31'd0, e.regw});
                chk("misaligned_exc", {31'd0, bus.misaligned_exc}, {31'd0, e.mis});
                chk("bus_err", {31'd0, bus.bus_err}, {31'd0, e.berr});
            end
        end else if (bus.misaligned_exc === 1'b1 || bus.bus_err === 1'b1) begin
            chk("exc_without_wb_valid", 32'd1, 32'd0);
        end
    end

    initial begin
        int n;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_branch", {31'd0, bus.branch_taken}, 32'd0);
        chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU pass-through
        push(32'h0000_00A5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        drive(32'h0000_00A5, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("alu_stall", {31'd0, bus.stall}, 32'd0);
        chk("alu_branch", {31'd0, bus.branch_taken}, 32'd0);

        // Write to x0 never enables the register write
        push(32'h0000_0055, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0055, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Branch taken, then the same instruction flushed
        push(32'h0000_0010, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0010, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("branch_taken", {31'd0, bus.branch_taken}, 32'd1);
        drive(32'h0000_0010, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("flush_branch", {31'd0, bus.branch_taken}, 32'd0);
        chk("flush_wb_valid", {31'd0, bus.wb_valid}, 32'd0);

        // Load, ack on 3rd WAIT cycle; a new instruction held during WAIT is ignored
        push(32'hDEAD_BEEF, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        drive(32'h0000_0100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("load_stall", {31'd0, bus.stall}, 32'd1);
        chk("load_we", {31'd0, bus.dmem_we}, 32'd0);
        bus.ex_valid = 1'b1; bus.alu_out = 32'h0000_0777; bus.rd = 5'd9; bus.reg_write = 1'b1;
        run_wait(3, 32'hDEAD_BEEF, 32'h0000_0100, n);
        clear_inputs();
        chk("load_wait_cycles", n, 32'd3);
        chk("load_stall_after", {31'd0, bus.stall}, 32'd0);

        // Misaligned store: no request
        push(32'h0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0);
        drive(32'h0000_0102, 32'h0000_00AA, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mis_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        chk("mis_pulse_end", {31'd0, bus.misaligned_exc}, 32'd0);

        // Aligned store, ack on 2nd cycle
        push(32'h0000_0200, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0200, 32'h1234_5678, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("store_we", {31'd0, bus.dmem_we}, 32'd1);
        chk("store_wdata", bus.dmem_wdata, 32'h1234_5678);
        run_wait(2, 32'hFFFF_FFFF, 32'h0000_0200, n);
        chk("store_wait_cycles", n, 32'd2);

        // Read and write both set: behaves as a store
        push(32'h0000_0300, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0300, 32'hCAFE_F00D, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rw_we", {31'd0, bus.dmem_we}, 32'd1);
        run_wait(1, 32'h1111_1111, 32'h0000_0300, n);
        chk("rw_wait_cycles", n, 32'd1);

        // Timeout with no ack
        push(32'h0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b1);
        drive(32'h0000_0400, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_wait(0, 32'h0, 32'h0000_0400, n);
        chk("timeout_req_cycles", n, 32'd16);
        chk("timeout_stall_after", {31'd0, bus.stall}, 32'd0);

        // Ack in the last permitted cycle completes normally; flush held meanwhile
        push(32'h0BAD_F00D, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        drive(32'h0000_0404, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.ex_valid = 1'b1; bus.flush = 1'b1;
        run_wait(16, 32'h0BAD_F00D, 32'h0000_0404, n);
        clear_inputs();
        chk("ack16_req_cycles", n, 32'd16);

        // Ack while no request is outstanding is ignored
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
        repeat (3) @(posedge clk);
        #1;
        clear_inputs();
        chk("stray_ack_stall", {31'd0, bus.stall}, 32'd0);

        // Reset on the 2nd WAIT cycle abandons the access
        drive(32'h0000_0500, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstwait_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rstwait_stall", {31'd0, bus.stall}, 32'd0);
        chk("rstwait_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rstwait_bus_err", {31'd0, bus.bus_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Following load is accepted normally
        push(32'h1357_9BDF, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        drive(32'h0000_0500, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("after_rst_req", {31'd0, bus.dmem_req}, 32'd1);
        run_wait(1, 32'h1357_9BDF, 32'h0000_0500, n);
        chk("after_rst_wait_cycles", n, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
